mp_pipe_core: RTL and testbench

MP_PIPE_CORE -- requirements
Module: mp_pipe_core

---
 rtl/mp_pkg.sv | 33 +++
 rtl/mp_alu_p.sv | 47 ++++
 rtl/mp_pipe_core.sv | 176 +++++++++++++++++
 tb/tb_mp_pipe_core.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// ---------------------------------------------------------------------------
// mp_pkg -- shared definitions for the mp_pipe_core datapath.
//   * opcode encodings (6-bit field in instruction[5:0])
//   * opcode_is_legal(): true for the eleven implemented operations
// No ports (package).
// ---------------------------------------------------------------------------
package mp_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_MIN = 6'd2;
  localparam logic [OPC_W-1:0] OP_ABS = 6'd3;
  localparam logic [OPC_W-1:0] OP_ADD = 6'd4;
  localparam logic [OPC_W-1:0] OP_AVG = 6'd6;
  localparam logic [OPC_W-1:0] OP_MAX = 6'd7;
  localparam logic [OPC_W-1:0] OP_XOR = 6'd8;
  localparam logic [OPC_W-1:0] OP_SUB = 6'd10;
  localparam logic [OPC_W-1:0] OP_AND = 6'd11;
  localparam logic [OPC_W-1:0] OP_NEG = 6'd12;
  localparam logic [OPC_W-1:0] OP_NOT = 6'd13;
  localparam logic [OPC_W-1:0] OP_OR  = 6'd14;

  function automatic logic opcode_is_legal(input logic [OPC_W-1:0] op);
    logic legal;
    case (op)
      OP_MIN, OP_ABS, OP_ADD, OP_AVG, OP_MAX, OP_XOR,
      OP_SUB, OP_AND, OP_NEG, OP_NOT, OP_OR: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mp_alu_p.sv
// ---------------------------------------------------------------------------
// mp_alu_p -- purely combinational ALU for mp_pipe_core.
// Ports:
//   i_op  6       opcode (see mp_pkg)
//   i_a   DATA_W  operand a (two's complement)
//   i_b   DATA_W  operand b (two's complement)
//   o_y   DATA_W  result; illegal opcodes yield zero (never stored upstream)
// ---------------------------------------------------------------------------
module mp_alu_p
  import mp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OPC_W-1:0]  i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);

  logic [DATA_W:0]   w_sum_ext;
  logic              w_a_lt_b;

  // Sign-extend both operands by one bit so the average never overflows;
  // the arithmetic shift right by one is then just dropping bit 0.
  assign w_sum_ext = {i_a[DATA_W-1], i_a} + {i_b[DATA_W-1], i_b};
  assign w_a_lt_b  = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD: o_y = i_a + i_b;
      OP_SUB: o_y = i_a - i_b;
      // Two's complement negate wraps, so the most-negative value maps to itself.
      OP_ABS: o_y = i_a[DATA_W-1] ? (~i_a + 1'b1) : i_a;
      OP_NEG: o_y = ~i_a + 1'b1;
      OP_MAX: o_y = w_a_lt_b ? i_b : i_a;
      OP_MIN: o_y = w_a_lt_b ? i_a : i_b;
      OP_AVG: o_y = w_sum_ext[DATA_W:1];
      OP_NOT: o_y = ~i_a;
      OP_OR:  o_y = i_a | i_b;
      OP_AND: o_y = i_a & i_b;
      OP_XOR: o_y = i_a ^ i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/mp_pipe_core.sv
// ---------------------------------------------------------------------------
// mp_pipe_core -- two-stage register-file ALU pipeline with full forwarding.
//   S1: latched opcode/operands/rd, ALU evaluates combinationally from S1.
//   S2: registered result/rd, drives res/res_rd/res_valid directly.
//   Register file is written only when S2's result is consumed.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/instruction instruction handshake
//                                 (op[5:0] rs1[10:6] rs2[15:11] rd[20:16])
//   res_valid/res_ready/res/res_rd result handshake
//   err                           one-cycle pulse after an illegal opcode is accepted
//   illegal_cnt                   saturating illegal-opcode count
//   cfg_we/cfg_addr/cfg_data      register preload port
// ---------------------------------------------------------------------------
module mp_pipe_core
  import mp_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int REG_N   = 32,
  parameter  int R0_ZERO = 1,
  parameter  int CNT_W   = 16,
  localparam int AW      = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res,
  output logic [AW-1:0]     res_rd,
  output logic              err,
  output logic [CNT_W-1:0]  illegal_cnt,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DATA_W-1:0] cfg_data
);

  // Register file and pipeline state
  logic [DATA_W-1:0] r_rf [REG_N];

  logic              r_s1_valid;
  logic [OPC_W-1:0]  r_s1_op;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [AW-1:0]     r_s1_rd;

  logic              r_s2_valid;
  logic [DATA_W-1:0] r_res;
  logic [AW-1:0]     r_res_rd;

  logic              r_err;
  logic [CNT_W-1:0]  r_illegal_cnt;

  // Decode
  logic [OPC_W-1:0]  w_op;
  logic [AW-1:0]     w_rd;
  logic [AW-1:0]     w_rs [2];
  logic [DATA_W-1:0] w_opnd_a;
  logic [DATA_W-1:0] w_opnd_b;
  logic              w_legal;
  logic              w_accept;
  logic              w_s2_load;
  logic              w_consume;
  logic [DATA_W-1:0] w_alu_y;
  logic              w_unused_instr;

  assign w_op    = instruction[5:0];
  assign w_rs[0] = instruction[6 +: AW];
  assign w_rs[1] = instruction[11 +: AW];
  assign w_rd    = instruction[16 +: AW];
  // Upper instruction bits (and field bits above AW) are don't-care.
  assign w_unused_instr = ^instruction;

  assign w_legal   = opcode_is_legal(w_op);
  assign w_s2_load = !r_s2_valid || res_ready;
  assign w_consume = r_s2_valid && res_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_accept  = in_valid && in_ready;

  mp_alu_p #(.DATA_W(DATA_W)) u_alu (
    .i_op (r_s1_op),
    .i_a  (r_s1_a),
    .i_b  (r_s1_b),
    .o_y  (w_alu_y)
  );

  // Operand fetch with forwarding. S1 holds the youngest in-flight write,
  // so it outranks S2, which outranks the architectural register file.
  // Register 0 short-circuits to zero before any rd comparison, so an
  // in-flight rd=0 result can never leak through forwarding.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [DATA_W-1:0] w_val;
      always_comb begin
        w_val = r_rf[w_rs[gi]];
        if ((R0_ZERO != 0) && (w_rs[gi] == '0)) begin
          w_val = '0;
        end else if (r_s1_valid && (r_s1_rd == w_rs[gi])) begin
          w_val = w_alu_y;
        end else if (r_s2_valid && (r_res_rd == w_rs[gi])) begin
          w_val = r_res;
        end
      end
    end
  endgenerate

  assign w_opnd_a = g_opnd[0].w_val;
  assign w_opnd_b = g_opnd[1].w_val;

  // Register file: the preload port is applied first so that a writeback to
  // the same address on the same edge overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (cfg_we && !((R0_ZERO != 0) && (cfg_addr == '0))) begin
        r_rf[cfg_addr] <= cfg_data;
      end
      if (w_consume && !((R0_ZERO != 0) && (r_res_rd == '0))) begin
        r_rf[r_res_rd] <= r_res;
      end
    end
  end

  // Pipeline stages, error pulse and illegal counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_op       <= '0;
      r_s1_a        <= '0;
      r_s1_b        <= '0;
      r_s1_rd       <= '0;
      r_s2_valid    <= 1'b0;
      r_res         <= '0;
      r_res_rd      <= '0;
      r_err         <= 1'b0;
      r_illegal_cnt <= '0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
        r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
      end

      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_res    <= w_alu_y;
          r_res_rd <= r_s1_rd;
        end
      end

      // Illegal opcodes are consumed from the input but leave S1 empty.
      if (w_accept && w_legal) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= w_op;
        r_s1_a     <= w_opnd_a;
        r_s1_b     <= w_opnd_b;
        r_s1_rd    <= w_rd;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  assign res_valid   = r_s2_valid;
  assign res         = r_res;
  assign res_rd      = r_res_rd;
  assign err         = r_err;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_mp_pipe_core.sv
// ---------------------------------------------------------------------------
// tb_mp_pipe_core -- directed + randomised bench for mp_pipe_core
// (DATA_W=32, REG_N=32, R0_ZERO=1, CNT_W=16). Expected results are pushed
// to a scoreboard queue at issue time (program-order reference model) and
// popped by a negedge monitor on every result handshake.
// ---------------------------------------------------------------------------
module tb_mp_pipe_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res;
  logic [4:0]  res_rd;
  logic        err;
  logic [15:0] illegal_cnt;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;

  always #5 clk = ~clk;

  mp_pipe_core dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res         (res),
    .res_rd      (res_rd),
    .err         (err),
    .illegal_cnt (illegal_cnt),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data)
  );

  typedef struct {
    logic [31:0] v;
    logic [4:0]  rd;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_rf [32];
  int          m_ill   = 0;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_res    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU
  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] s;
    case (op)
      6'd4:  return a + b;
      6'd10: return a - b;
      6'd3:  return ($signed(a) < 0) ? 32'd0 - a : a;
      6'd12: return 32'd0 - a;
      6'd7:  return ($signed(a) > $signed(b)) ? a : b;
      6'd2:  return ($signed(a) < $signed(b)) ? a : b;
      6'd6:  begin s = $signed({a[31], a}) + $signed({b[31], b}); return s[32:1]; end
      6'd13: return ~a;
      6'd14: return a | b;
      6'd11: return a & b;
      6'd8:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : m_rf[r];
  endfunction

  // Scoreboard monitor: one line per consumed result.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (q.size() == 0) begin
        chk("spurious_res_valid", {63'd0, res_valid}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_res++;
        $display("result %0d: rd=%0d res=%08h (exp rd=%0d res=%08h)", n_res, res_rd, res, e.rd, e.v);
        chk("res", {32'd0, res}, {32'd0, e.v});
        chk("res_rd", {59'd0, res_rd}, {59'd0, e.rd});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [4:0] a, input logic [31:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    step();
    cfg_we = 1'b0;
    if (a != 5'd0) m_rf[a] = d;
  endtask

  // Offer one instruction (call at posedge+1); returns at posedge+1 after acceptance.
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, output int waited);
    logic [10:0] junk;
    junk        = 11'($urandom);
    in_valid    = 1'b1;
    instruction = {junk, rd, rs2, rs1, op};
    waited      = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        n_assert++;
        n_fail++;
        $error("FAIL accept_timeout observed=in_ready_low expected=accept op=%0d", op);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("issue op=%0d rd=%0d rs1=%0d rs2=%0d waited=%0d", op, rd, rs1, rs2, waited);
  endtask

  task automatic issue_k(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] expv, output int waited);
    exp_t e;
    e.v  = expv;
    e.rd = rd;
    q.push_back(e);
    if (rd != 5'd0) m_rf[rd] = expv;
    send(op, rd, rs1, rs2, waited);
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    int w;
    issue_k(op, rd, rs1, rs2, model(op, mread(rs1), mread(rs2)), w);
  endtask

  task automatic issue_illegal(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    int w;
    m_ill++;
    send(op, rd, rs1, rs2, w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_queue_size", 64'(q.size()), 64'd0);
    step();
  endtask

  logic [5:0]  legal_ops [11] = '{6'd4, 6'd10, 6'd3, 6'd12, 6'd7, 6'd2, 6'd6, 6'd13, 6'd14, 6'd11, 6'd8};
  logic [5:0]  bad_ops   [6]  = '{6'd0, 6'd1, 6'd5, 6'd9, 6'd15, 6'd63};
  logic [31:0] held_res;
  logic [4:0]  held_rd;
  logic        rnd_done;
  int          w;

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    rst = 1'b1; in_valid = 1'b0; instruction = 32'd0; res_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = 5'd0; cfg_data = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res", {32'd0, res}, 64'd0);
    chk("rst_res_rd", {59'd0, res_rd}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_illegal_cnt", {48'd0, illegal_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    step();

    // Preload and single ADD latency
    cfg(5'd1, 32'd11930);
    cfg(5'd2, 32'd5348);
    issue_k(6'd4, 5'd3, 5'd1, 5'd2, 32'd17278, w);
    @(negedge clk);
    chk("lat_early_res_valid", {63'd0, res_valid}, 64'd0);
    @(negedge clk);
    chk("lat_res_valid", {63'd0, res_valid}, 64'd1);
    chk("lat_res", {32'd0, res}, 64'd17278);
    chk("lat_res_rd", {59'd0, res_rd}, 64'd3);
    step();

    // Back-to-back dependent ADD then SUB
    issue_k(6'd4, 5'd3, 5'd1, 5'd2, 32'd17278, w);
    issue_k(6'd10, 5'd4, 5'd3, 5'd2, 32'd11930, w);
    chk("b2b_no_stall", 64'(w), 64'd0);
    @(negedge clk);
    chk("b2b_first", {32'd0, res}, 64'd17278);
    @(negedge clk);
    chk("b2b_second", {32'd0, res}, 64'd11930);
    chk("b2b_second_valid", {63'd0, res_valid}, 64'd1);
    step();

    // Illegal opcode 5 targeting r3
    issue_illegal(6'd5, 5'd3, 5'd1, 5'd2);
    @(negedge clk);
    chk("ill_err_pulse", {63'd0, err}, 64'd1);
    chk("ill_cnt", {48'd0, illegal_cnt}, 64'd1);
    chk("ill_no_res_valid", {63'd0, res_valid}, 64'd0);
    @(negedge clk);
    chk("ill_err_cleared", {63'd0, err}, 64'd0);
    chk("ill_no_res_valid2", {63'd0, res_valid}, 64'd0);
    step();
    issue_k(6'd4, 5'd3, 5'd3, 5'd0, 32'd17278, w);
    drain();

    // Back-pressure: res_ready low for 3 edges while 4 instructions stream
    res_ready = 1'b0;
    fork
      begin
        issue(6'd4, 5'd15, 5'd1, 5'd2);
        issue(6'd10, 5'd16, 5'd15, 5'd2);
        issue(6'd8, 5'd17, 5'd15, 5'd16);
        issue(6'd14, 5'd18, 5'd17, 5'd1);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_res_valid", {63'd0, res_valid}, 64'd1);
        held_res = res;
        held_rd  = res_rd;
        @(posedge clk);
        #1;
        chk("bp_res_held", {32'd0, res}, {32'd0, held_res});
        chk("bp_rd_held", {59'd0, res_rd}, {59'd0, held_rd});
        chk("bp_in_ready_still_low", {63'd0, in_ready}, 64'd0);
        res_ready = 1'b1;
      end
    join
    drain();

    // Boundary values and register 0
    cfg(5'd5, 32'h7FFF_FFFF);
    cfg(5'd6, 32'h8000_0000);
    cfg(5'd7, 32'hFFFF_FFFB);
    cfg(5'd8, 32'd3);
    cfg(5'd0, 32'd99);
    issue_k(6'd6,  5'd9,  5'd5, 5'd5, 32'h7FFF_FFFF, w);
    issue_k(6'd3,  5'd10, 5'd6, 5'd6, 32'h8000_0000, w);
    issue_k(6'd2,  5'd11, 5'd7, 5'd8, 32'hFFFF_FFFB, w);
    issue_k(6'd12, 5'd12, 5'd6, 5'd6, 32'h8000_0000, w);
    issue_k(6'd7,  5'd13, 5'd7, 5'd8, 32'd3, w);
    issue_k(6'd4,  5'd0,  5'd1, 5'd2, 32'd17278, w);
    issue_k(6'd4,  5'd14, 5'd0, 5'd1, 32'd11930, w);
    drain();

    // Randomised stream with random back-pressure and hazards on r0..r7
    for (int i = 1; i < 8; i++) cfg(5'(i), $urandom);
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          if ($urandom_range(0, 7) == 0)
            issue_illegal(bad_ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)), 5'd1, 5'd2);
          else
            issue(legal_ops[$urandom_range(0, 10)], 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          step();
          res_ready = ($urandom_range(0, 3) != 0);
        end
        res_ready = 1'b1;
      end
    join
    drain();
    chk("rnd_illegal_cnt", {48'd0, illegal_cnt}, 64'(m_ill));

    // Reset with both stages full; reset also overrides cfg_we and input handshake
    res_ready = 1'b0;
    issue(6'd4, 5'd20, 5'd1, 5'd2);
    issue(6'd4, 5'd21, 5'd20, 5'd1);
    rst         = 1'b1;
    cfg_we      = 1'b1;
    cfg_addr    = 5'd1;
    cfg_data    = 32'h5555_5555;
    in_valid    = 1'b1;
    instruction = {11'd0, 5'd22, 5'd0, 5'd0, 6'd5};
    step();
    rst = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_ill = 0;
    @(negedge clk);
    chk("rst2_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst2_illegal_cnt", {48'd0, illegal_cnt}, 64'd0);
    chk("rst2_err", {63'd0, err}, 64'd0);
    chk("rst2_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    issue_k(6'd4, 5'd20, 5'd20, 5'd0, 32'd0, w);
    issue_k(6'd4, 5'd21, 5'd21, 5'd0, 32'd0, w);
    issue_k(6'd4, 5'd1,  5'd1,  5'd0, 32'd0, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
